fetch_unit: RTL

Fetch-stage front end: owns the architectural PC register and drives the instruction-bus request/response handshake for it. Each cycle it exports the current PC to the next-PC selector and takes back `pc_selected`. It registers fetched instructions into the F→D pipeline register and drops responses belonging to squashed fetches. It sits between the next-PC selector, the instruction bus, and decode.

---
 rtl/fetch_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
//   Fetch-stage front end. Owns the architectural PC, runs the instruction-bus
//   request/response handshake for it, and fills the F->D pipeline register.
//   Responses belonging to squashed fetches are dropped without touching F.
//
// Ports
//   clk, reset      clock and synchronous active-high reset
//   pc              current fetch PC, exported to the next-PC selector
//   pc_selected     next PC from the selector (pc+4 or a redirect target)
//   redirect        pipeline flush; pc_selected is a non-sequential target
//   stall           decode cannot accept; F must hold
//   ireq_valid      instruction-bus request valid
//   ireq_addr       request address (always equals pc)
//   iresp_data_ok   response valid (may coincide with the request cycle)
//   iresp_data      instruction word
//   f_valid/f_pc/f_instr  F pipeline register
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_REQ     | request for pc on the bus, waiting for / consuming response
// S_HOLD    | response parked in r_buf because decode stalled; no request
// S_DISCARD | squashed request still outstanding; target parked in r_pend

module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] pc,
    input  logic [63:0] pc_selected,
    input  logic        redirect,
    input  logic        stall,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_instr
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [63:0] r_pc;
    logic        r_f_valid;
    logic [63:0] r_f_pc;
    logic [31:0] r_f_instr;
    logic [31:0] r_buf;
    logic [63:0] r_pend_pc;

    logic        w_pc_load;
    logic [63:0] w_pc_next;
    logic        w_f_load;
    logic [31:0] w_f_word;
    logic        w_f_kill;
    logic        w_buf_load;
    logic        w_pend_load;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; redirect takes priority over stall everywhere
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_REQ: begin
                if (iresp_data_ok) begin
                    if (!redirect && stall) begin
                        w_next_state = S_HOLD;
                    end
                end else if (redirect) begin
                    w_next_state = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    w_next_state = S_REQ;
                end
            end
            S_DISCARD: begin
                if (iresp_data_ok) begin
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_REQ;
        endcase
    end

    // Output / datapath-control logic
    always_comb begin
        ireq_valid  = !reset && (r_state != S_HOLD);
        ireq_addr   = r_pc;
        pc          = r_pc;
        f_valid     = r_f_valid;
        f_pc        = r_f_pc;
        f_instr     = r_f_instr;

        w_pc_load   = 1'b0;
        w_pc_next   = pc_selected;
        w_f_load    = 1'b0;
        w_f_word    = iresp_data;
        w_f_kill    = 1'b0;
        w_buf_load  = 1'b0;
        w_pend_load = 1'b0;

        case (r_state)
            S_REQ: begin
                if (iresp_data_ok) begin
                    if (redirect) begin
                        w_pc_load = 1'b1;
                        w_f_kill  = 1'b1;
                    end else if (!stall) begin
                        w_pc_load = 1'b1;
                        w_f_load  = 1'b1;
                    end else begin
                        w_buf_load = 1'b1;
                    end
                end else if (redirect) begin
                    // pc stays put so the outstanding bus address is stable
                    w_pend_load = 1'b1;
                    w_f_kill    = 1'b1;
                end else if (!stall) begin
                    w_f_kill = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc_load = 1'b1;
                    w_f_kill  = 1'b1;
                end else if (!stall) begin
                    w_pc_load = 1'b1;
                    w_f_load  = 1'b1;
                    w_f_word  = r_buf;
                end
            end
            S_DISCARD: begin
                w_f_kill = 1'b1;
                if (redirect) begin
                    w_pend_load = 1'b1;
                end
                if (iresp_data_ok) begin
                    w_pc_load = 1'b1;
                    // a redirect arriving with the response is newer than r_pend_pc
                    w_pc_next = redirect ? pc_selected : r_pend_pc;
                end
            end
            default: begin
                w_f_kill = 1'b1;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_f_valid <= 1'b0;
            r_f_pc    <= 64'd0;
            r_f_instr <= 32'd0;
            r_buf     <= 32'd0;
            r_pend_pc <= 64'd0;
        end else begin
            if (w_pc_load) begin
                r_pc <= w_pc_next;
            end
            if (w_f_load) begin
                r_f_valid <= 1'b1;
                r_f_pc    <= r_pc;
                r_f_instr <= w_f_word;
            end else if (w_f_kill) begin
                r_f_valid <= 1'b0;
            end
            if (w_buf_load) begin
                r_buf <= iresp_data;
            end
            if (w_pend_load) begin
                r_pend_pc <= pc_selected;
            end
        end
    end

endmodule
